// File: rtl/uart_pkg.sv
// uart_pkg: baud divisor helper and FSM state encodings shared by the
// uart_buffered design.
package uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {IRQ_IDLE, IRQ_PENDING} irq_state_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive word FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       cnt;
    logic              do_push, do_pop;

    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(FIFO_DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp];

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(do_push);
            rp  <= rp + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_buffered.sv
// uart_buffered: 8N1-style UART with a receive FIFO, sticky error flags and a
// receive interrupt acknowledged by a register write.
module uart_buffered
    import uart_pkg::*;
#(
    parameter int          CLK_HZ     = 50000000,
    parameter int          BAUD       = 115200,
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  IRQ_ADDR   = 8'd252
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              tx,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_pop,
    input  logic [7:0]        access_addr,
    input  logic              reg_w_en,
    output logic              int_req,
    output logic              rx_overrun,
    output logic              rx_frame_err
);
    localparam int DIV  = calc_div(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int BW   = $clog2(DATA_W + 1);

    tx_state_t         tx_st, tx_nx;
    logic [CW-1:0]     tx_cnt;
    logic [BW-1:0]     tx_idx;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_tick;

    assign tx_tick = tx_cnt == CW'(DIV - 1);
    assign tx_busy = tx_st != TX_IDLE;
    assign tx      = (tx_st == TX_START) ? 1'b0 : (tx_st == TX_DATA) ? tx_sh[0] : 1'b1;

    always_comb begin
        tx_nx = tx_st;
        case (tx_st)
            TX_IDLE:  if (tx_valid) tx_nx = TX_START;
            TX_START: if (tx_tick) tx_nx = TX_DATA;
            TX_DATA:  if (tx_tick && tx_idx == BW'(DATA_W - 1)) tx_nx = TX_STOP;
            TX_STOP:  if (tx_tick) tx_nx = TX_IDLE;
            default:  tx_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st  <= TX_IDLE;
            tx_cnt <= '0;
            tx_idx <= '0;
            tx_sh  <= '0;
        end else begin
            tx_st  <= tx_nx;
            tx_cnt <= (tx_st == TX_IDLE || tx_tick) ? '0 : tx_cnt + CW'(1);
            tx_idx <= (tx_st != TX_DATA) ? '0 : tx_tick ? tx_idx + BW'(1) : tx_idx;
            if (tx_st == TX_IDLE && tx_valid) tx_sh <= tx_data;
            else if (tx_st == TX_DATA && tx_tick) tx_sh <= tx_sh >> 1;
        end
    end

    rx_state_t         rx_st, rx_nx;
    logic [1:0]        sync;
    logic              rx_s, rx_d, rx_fall, rx_tick, rx_half, rx_brk;
    logic [CW-1:0]     rx_cnt;
    logic [BW-1:0]     rx_idx;
    logic [DATA_W-1:0] rx_sh;
    logic              push_q, full, empty, push_ok, ovr_set, ferr_set, ack;
    irq_state_t        irq_st, irq_nx;

    assign rx_s    = sync[1];
    assign rx_fall = rx_d && !rx_s;
    assign rx_tick = rx_cnt == CW'(DIV - 1);
    assign rx_half = rx_cnt == CW'(HALF - 1);

    always_comb begin
        rx_nx = rx_st;
        case (rx_st)
            RX_IDLE:  if (rx_fall) rx_nx = RX_START;
            RX_START: if (rx_half) rx_nx = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_idx == BW'(DATA_W - 1)) rx_nx = RX_STOP;
            RX_STOP:  if (rx_tick && rx_s) rx_nx = RX_IDLE;
            default:  rx_nx = RX_IDLE;
        endcase
    end

    // A low stop bit parks the counter on the sample point until the line idles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= 2'b11;
            rx_d   <= 1'b1;
            rx_st  <= RX_IDLE;
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_sh  <= '0;
            rx_brk <= 1'b0;
            push_q <= 1'b0;
        end else begin
            sync   <= {sync[0], rx};
            rx_d   <= rx_s;
            rx_st  <= rx_nx;
            rx_cnt <= (rx_st != rx_nx || rx_st == RX_IDLE || (rx_st == RX_DATA && rx_tick)) ? '0
                    : (rx_st == RX_STOP && rx_tick) ? rx_cnt : rx_cnt + CW'(1);
            rx_idx <= (rx_st != RX_DATA) ? '0 : rx_tick ? rx_idx + BW'(1) : rx_idx;
            if (rx_st == RX_DATA && rx_tick) rx_sh <= {rx_s, rx_sh[DATA_W-1:1]};
            rx_brk <= rx_st == RX_STOP && rx_tick && !rx_s;
            push_q <= rx_st == RX_STOP && rx_tick && rx_s && !rx_brk;
        end
    end

    uart_rx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .pop   (rx_pop),
        .din   (rx_sh),
        .head  (rx_data),
        .full  (full),
        .empty (empty)
    );

    assign rx_valid = !empty;
    assign push_ok  = push_q && (!full || rx_pop);
    assign ovr_set  = push_q && full && !rx_pop;
    assign ferr_set = rx_st == RX_STOP && rx_tick && !rx_s && !rx_brk;
    assign ack      = reg_w_en && access_addr == IRQ_ADDR;
    assign int_req  = irq_st == IRQ_PENDING;

    always_comb begin
        irq_nx = push_ok ? IRQ_PENDING : ack ? IRQ_IDLE : irq_st;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_st       <= IRQ_IDLE;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            irq_st       <= irq_nx;
            rx_overrun   <= ovr_set ? 1'b1 : ack ? 1'b0 : rx_overrun;
            rx_frame_err <= ferr_set ? 1'b1 : ack ? 1'b0 : rx_frame_err;
        end
    end

endmodule

// File: doc/uart_buffered.md
UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_W, default 8, data bits per frame (5..9).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, RX FIFO entries (power of 2, >=2).
REQ-005 SHALL have parameter IRQ_ADDR, default 8'd252, address whose register write acknowledges the interrupt.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port rx  input  1  asynchronous serial input, idle high.
REQ-009 SHALL have port tx  output  1  serial output, idle high.
REQ-010 SHALL have port tx_data  input  DATA_W  word to transmit.
REQ-011 SHALL have port tx_valid  input  1  transmit request, sampled when tx_busy low.
REQ-012 SHALL have port tx_busy  output  1  transmitter occupied.
REQ-013 SHALL have port rx_data  output  DATA_W  FIFO head word, valid when rx_valid high.
REQ-014 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-015 SHALL have port rx_pop  input  1  consume FIFO head.
REQ-016 SHALL have port access_addr  input  8  CPU register address.
REQ-017 SHALL have port reg_w_en  input  1  CPU register write strobe.
REQ-018 SHALL have port int_req  output  1  receive interrupt request.
REQ-019 SHALL have ports rx_overrun, rx_frame_err  output  1 each  sticky error flags.

Function
REQ-020 Bit period DIV SHALL be round(CLK_HZ/BAUD), computed at elaboration (434 at defaults); frame = start 0, DATA_W bits LSB first, 1 stop bit, no parity.
REQ-021 TX FSM SHALL use states IDLE, START, DATA, STOP; tx_valid with tx_busy low latches tx_data, tx_busy high from next cycle until STOP completes (DIV*(DATA_W+2) cycles).
REQ-022 tx_valid while tx_busy high SHALL be ignored; tx_busy SHALL fall on the cycle tx returns to IDLE, and a tx_valid in that cycle starts the next frame back-to-back.
REQ-023 rx SHALL pass a 2-flop synchroniser; RX FSM states IDLE, START, DATA, STOP.
REQ-024 Falling edge in IDLE SHALL enter START; synchronised rx re-sampled at DIV/2; if high, return to IDLE (glitch rejection), else sample each data and stop bit at bit centre.
REQ-025 Stop bit sampled 0 SHALL discard the word and set rx_frame_err; RX returns to IDLE once rx is high.
REQ-026 Valid frame SHALL push the word into the FIFO one cycle after the stop sample.
REQ-027 Push when full without simultaneous pop SHALL drop the new word, keep FIFO contents, set rx_overrun.
REQ-028 Push and pop in the same cycle SHALL both succeed at any occupancy (no overrun when full); rx_pop when empty SHALL be ignored.
REQ-029 rx_data SHALL be the head word combinationally from storage; pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-030 IRQ FSM SHALL have states IDLE (int_req 0) and PENDING (int_req 1), int_req registered.
REQ-031 IDLE->PENDING on successful push; PENDING->IDLE on reg_w_en high with access_addr==IRQ_ADDR.
REQ-032 Acknowledge and push in the same cycle SHALL leave the IRQ FSM in PENDING.
REQ-033 The acknowledge write SHALL also clear rx_overrun and rx_frame_err, unless an error is set in that same cycle (set wins).

Reset
REQ-034 On reset high at a clock edge: tx=1, tx_busy=0, rx_valid=0, int_req=0, rx_overrun=0, rx_frame_err=0, FIFO empty, all FSMs IDLE, synchroniser loaded with 1.
REQ-035 Reset mid-frame SHALL abort TX (tx high next cycle) and RX (partial word discarded, no push).

Structure
REQ-036 Shared package uart_pkg SHALL hold the DIV elaboration function and the TX/RX/IRQ state enumerations.
REQ-037 RX FIFO SHALL be sub-module uart_rx_fifo (params DATA_W, FIFO_DEPTH; push/pop/full/empty/head).

Verification
REQ-038 Defaults, tx_valid pulse with tx_data=8'hA5 -> tx line 0,1,0,1,0,0,1,0,1,1 each 434 cycles; tx_busy high 4340 cycles.
REQ-039 Drive rx frame 8'h3C -> rx_valid=1, rx_data=8'h3C, int_req=1; write access_addr=252 reg_w_en=1 -> int_req=0 next cycle.
REQ-040 Send 5 frames 8'h01..8'h05, no pops -> FIFO holds 01..04, rx_overrun=1; pops return 01,02,03,04 then rx_valid=0.
REQ-041 rx low pulse of 100 cycles -> no push, rx_frame_err=0; frame 8'h55 with stop bit 0 -> no push, rx_frame_err=1.
REQ-042 FIFO full and pop coincident with push of 8'h77 -> no overrun, 8'h77 read last.
REQ-043 Reset asserted mid-TX and mid-RX -> tx=1 next cycle, rx_valid=0, int_req=0, all flags 0.
